// File: rtl/pipeline_run_controller.sv
// pipeline_run_controller
//
// Run-control sequencer for a 5-stage pipeline. Host commands (RUN, STEP N,
// HALT) are turned into one pipeline enable that gates the PC and every
// inter-stage register. When the end-of-program word shows up at fetch, the
// controller holds fetch and keeps the pipeline enabled long enough to
// retire the older instructions, then parks in DONE until reset. A
// saturating count of enabled cycles is kept for debug readout.
//
// Parameters:
//   HALT_WORD     instruction word marking end of program
//   DRAIN_CYCLES  enabled cycles after the halt-word cycle (1..15)
//   CNT_W         width of cycle_count
//
// Ports:
//   clk            clock, all state updates on rising edge
//   reset          synchronous active-high reset, overrides every input
//   cmd_valid      command offered this cycle
//   cmd_code       00 NOP, 01 RUN, 10 STEP, 11 HALT
//   step_count     cycle count for STEP, sampled only on a STEP transfer
//   cmd_ready      controller accepts a command this cycle
//   instruction_IF word currently presented by the fetch block
//   pipe_enable    PC and pipeline registers advance this cycle
//   fetch_hold     PC write disabled and IF/ID loads a nop
//   state          000 IDLE, 001 RUN, 010 STEP, 011 DRAIN, 100 DONE
//   busy           state is RUN, STEP or DRAIN
//   done           state is DONE
//   cycle_count    saturating number of cycles with pipe_enable=1

module pipeline_run_controller #(
  parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF,
  parameter int          DRAIN_CYCLES = 4,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_code,
  input  logic [15:0]      step_count,
  output logic             cmd_ready,
  input  logic [31:0]      instruction_IF,
  output logic             pipe_enable,
  output logic             fetch_hold,
  output logic [2:0]       state,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [2:0] ST_IDLE  = 3'b000;
  localparam logic [2:0] ST_RUN   = 3'b001;
  localparam logic [2:0] ST_STEP  = 3'b010;
  localparam logic [2:0] ST_DRAIN = 3'b011;
  localparam logic [2:0] ST_DONE  = 3'b100;

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_HALT = 2'b11;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

  logic [2:0]       state_q, state_d;
  logic [15:0]      remaining_q, remaining_d;
  logic [3:0]       drain_q, drain_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

  logic cmd_xfer;
  logic halt_hit;

  // Everything except fetch_hold is a pure decode of the registered state.
  assign cmd_ready   = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign pipe_enable = (state_q == ST_RUN) || (state_q == ST_STEP) ||
                       (state_q == ST_DRAIN);
  assign busy        = pipe_enable;
  assign done        = (state_q == ST_DONE);
  assign state       = state_q;
  assign cycle_count = cycle_count_q;

  assign cmd_xfer = cmd_valid && cmd_ready;

  // The halt word is caught while it is still at fetch so it never loads
  // into IF/ID; hence the combinational path to fetch_hold.
  assign halt_hit = ((state_q == ST_RUN) || (state_q == ST_STEP)) &&
                    (instruction_IF == HALT_WORD);

  // Only asserted in enabled states, so it is low whenever pipe_enable is.
  assign fetch_hold = halt_hit || (state_q == ST_DRAIN);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    drain_d     = drain_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_xfer) begin
          case (cmd_code)
            CMD_RUN: state_d = ST_RUN;
            CMD_STEP: begin
              // STEP 0 is accepted but does nothing.
              if (step_count != 16'd0) begin
                state_d     = ST_STEP;
                remaining_d = step_count;
              end
            end
            CMD_NOP, CMD_HALT: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
          endcase
        end
      end

      ST_RUN: begin
        // A halt hit wins over a HALT command in the same cycle; RUN, STEP
        // and NOP are accepted and ignored here.
        if (halt_hit) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end else if (cmd_xfer && (cmd_code == CMD_HALT)) begin
          state_d = ST_IDLE;
        end
      end

      ST_STEP: begin
        if (halt_hit) begin
          // Any steps still outstanding are discarded.
          state_d     = ST_DRAIN;
          drain_d     = DRAIN_LOAD;
          remaining_d = 16'd0;
        end else begin
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_DRAIN: begin
        drain_d = drain_q - 4'd1;
        if (drain_q == 4'd1) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: state_d = ST_DONE;

      // Unused encodings fall back to a safe stopped state.
      default: state_d = ST_IDLE;
    endcase
  end

  // Saturating enabled-cycle counter.
  always_comb begin
    cycle_count_d = cycle_count_q;
    if (pipe_enable && (cycle_count_q != {CNT_W{1'b1}})) begin
      cycle_count_d = cycle_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      remaining_q   <= 16'd0;
      drain_q       <= 4'd0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      drain_q       <= drain_d;
      cycle_count_q <= cycle_count_d;
    end
  end

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Self-checking bench for pipeline_run_controller. A reference model that
// tracks absolute cycle deadlines (step end, done time) predicts every
// output each cycle; directed scenarios add literal expectations, then a
// randomized phase runs against the same model. A second instance built
// with CNT_W=4 covers counter saturation.

module tb_pipeline_run_controller;

  localparam logic [31:0] HW = 32'hFFFF_FFFF;
  localparam int          DC = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_code = 2'b00;
  logic [15:0] step_count = 16'd0;
  logic [31:0] instruction_IF = 32'h0000_0013;
  logic        cmd_ready, pipe_enable, fetch_hold, busy, done;
  logic [2:0]  state;
  logic [31:0] cycle_count;

  // Saturation instance
  logic        s_reset = 1'b0;
  logic        s_cmd_valid = 1'b0;
  logic [1:0]  s_cmd_code = 2'b00;
  logic [15:0] s_step_count = 16'd0;
  logic [31:0] s_instruction_IF = 32'h0000_0013;
  logic        s_cmd_ready, s_pipe_enable, s_fetch_hold, s_busy, s_done;
  logic [2:0]  s_state;
  logic [3:0]  s_cycle_count;

  always #5 clk = ~clk;

  pipeline_run_controller #(.HALT_WORD(HW), .DRAIN_CYCLES(DC), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .step_count(step_count), .cmd_ready(cmd_ready),
    .instruction_IF(instruction_IF), .pipe_enable(pipe_enable),
    .fetch_hold(fetch_hold), .state(state), .busy(busy), .done(done),
    .cycle_count(cycle_count)
  );

  pipeline_run_controller #(.HALT_WORD(HW), .DRAIN_CYCLES(DC), .CNT_W(4)) u_sat (
    .clk(clk), .reset(s_reset), .cmd_valid(s_cmd_valid), .cmd_code(s_cmd_code),
    .step_count(s_step_count), .cmd_ready(s_cmd_ready),
    .instruction_IF(s_instruction_IF), .pipe_enable(s_pipe_enable),
    .fetch_hold(s_fetch_hold), .state(s_state), .busy(s_busy), .done(s_done),
    .cycle_count(s_cycle_count)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Modes use the externally visible state codes. Timing is tracked with
  // absolute cycle numbers: step_end is the first cycle back in IDLE,
  // done_at the first cycle in DONE.
  int     m_mode   = 0;
  longint cyc      = 0;
  longint step_end = 0;
  longint done_at  = 0;
  longint m_count  = 0;
  bit     chk_en   = 0;
  localparam longint CNT_MAX = 64'd4294967295;

  function automatic bit m_enabled();
    return (m_mode == 1) || (m_mode == 2) || (m_mode == 3);
  endfunction

  function automatic bit m_hit();
    return ((m_mode == 1) || (m_mode == 2)) && (instruction_IF == HW);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_mode  = 0;
      m_count = 0;
    end else begin
      bit xfer;
      bit hit;
      hit  = m_hit();
      xfer = cmd_valid && ((m_mode == 0) || (m_mode == 1));
      if (m_enabled() && m_count < CNT_MAX) m_count = m_count + 1;
      if (hit) begin
        m_mode  = 3;
        done_at = cyc + DC + 1;
      end else begin
        case (m_mode)
          0: if (xfer) begin
               if (cmd_code == 2'b01) m_mode = 1;
               else if (cmd_code == 2'b10 && step_count != 0) begin
                 m_mode   = 2;
                 step_end = cyc + 1 + step_count;
               end
             end
          1: if (xfer && cmd_code == 2'b11) m_mode = 0;
          2: if (cyc + 1 == step_end) m_mode = 0;
          3: if (cyc + 1 == done_at) m_mode = 4;
          default: ;
        endcase
      end
    end
    cyc = cyc + 1;
  end

  // One compare process, every cycle, on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("state", state, m_mode);
      check("pipe_enable", pipe_enable, m_enabled());
      check("fetch_hold", fetch_hold, m_hit() || (m_mode == 3));
      check("cmd_ready", cmd_ready, (m_mode == 0) || (m_mode == 1));
      check("busy", busy, m_enabled());
      check("done", done, m_mode == 4);
      check("cycle_count", cycle_count, m_count);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    instruction_IF = 32'h0000_0013;
    tick();
    reset = 1'b0;
  endtask

  task automatic send(input logic [1:0] code, input logic [15:0] n);
    cmd_valid  = 1'b1;
    cmd_code   = code;
    step_count = n;
    tick();
    cmd_valid  = 1'b0;
  endtask

  initial begin
    do_reset();
    chk_en = 1;
    check("rst_state", state, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_count", cycle_count, 0);

    // STEP 3: three enabled cycles then back to IDLE
    send(2'b10, 16'd3);
    check("step_pe", pipe_enable, 1);
    check("step_ready", cmd_ready, 0);
    repeat (3) tick();
    check("step_end_state", state, 0);
    check("step_count3", cycle_count, 3);
    check("step_end_ready", cmd_ready, 1);

    // RUN 10 cycles, HALT, resume without clearing the count
    do_reset();
    send(2'b01, 16'd0);
    repeat (9) tick();
    send(2'b11, 16'd0);
    check("halt_pe", pipe_enable, 0);
    check("halt_count10", cycle_count, 10);
    tick();
    check("frozen_count", cycle_count, 10);
    send(2'b01, 16'd0);
    repeat (2) tick();
    check("resume_count12", cycle_count, 12);

    // Halt word during RUN -> DRAIN h+1..h+4, DONE at h+5
    do_reset();
    send(2'b01, 16'd0);
    repeat (2) tick();
    instruction_IF = HW;
    #1;
    check("hit_fetch_hold", fetch_hold, 1);
    check("hit_pe", pipe_enable, 1);
    tick();
    instruction_IF = 32'h0000_0013;
    check("drain_state", state, 3);
    repeat (3) tick();
    check("drain_last", state, 3);
    tick();
    check("done_flag", done, 1);
    check("done_count7", cycle_count, 7);
    cmd_valid = 1'b1; cmd_code = 2'b01;
    #1;
    check("done_ready", cmd_ready, 0);
    tick();
    cmd_valid = 1'b0;
    check("done_stays", state, 4);

    // Halt word coincident with a HALT command
    do_reset();
    send(2'b01, 16'd0);
    instruction_IF = HW;
    send(2'b11, 16'd0);
    instruction_IF = 32'h0000_0013;
    check("hit_vs_halt", state, 3);
    repeat (5) tick();

    // Halt word on the last STEP cycle
    do_reset();
    send(2'b10, 16'd2);
    tick();
    instruction_IF = HW;
    tick();
    instruction_IF = 32'h0000_0013;
    check("hit_last_step", state, 3);
    tick();

    // Reset mid-DRAIN with a RUN command offered
    reset = 1'b1; cmd_valid = 1'b1; cmd_code = 2'b01;
    tick();
    reset = 1'b0; cmd_valid = 1'b0;
    check("rst_drain_state", state, 0);
    check("rst_drain_count", cycle_count, 0);
    tick();
    check("rst_cmd_dropped", pipe_enable, 0);

    // STEP 0 has no effect
    send(2'b10, 16'd0);
    check("step0_state", state, 0);
    tick();
    check("step0_pe", pipe_enable, 0);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(0, 99) == 0);
      cmd_valid      = $urandom_range(0, 1);
      cmd_code       = 2'($urandom_range(0, 3));
      step_count     = 16'($urandom_range(0, 6));
      instruction_IF = ($urandom_range(0, 29) == 0) ? HW : $urandom_range(0, 32'h7FFF_FFFF);
      tick();
    end
    reset = 1'b0; cmd_valid = 1'b0; instruction_IF = 32'h0000_0013;

    // Saturation with CNT_W=4
    s_reset = 1'b1;
    tick();
    s_reset = 1'b0;
    check("sat_rst", s_cycle_count, 0);
    s_cmd_valid = 1'b1; s_cmd_code = 2'b01;
    tick();
    s_cmd_valid = 1'b0;
    repeat (5) tick();
    check("sat_count5", s_cycle_count, 5);
    repeat (15) tick();
    check("sat_count15", s_cycle_count, 15);
    check("sat_still_run", s_state, 1);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_run_controller.md
# pipeline_run_controller

Run-control sequencer for the 5-stage pipeline. It turns host commands (RUN, STEP N, HALT) into a single pipeline enable, which gates the PC and all inter-stage registers. It detects the end-of-program instruction word at fetch, then drains the instructions already in ID/EX/MEM/WB before parking in DONE. It also keeps a saturating count of enabled cycles for debug readout.

## Interface
Parameters:
- HALT_WORD, 32'hFFFF_FFFF, instruction word that marks end of program
- DRAIN_CYCLES, 4, enabled cycles after the halt-word cycle needed to retire older instructions (range 1..15)
- CNT_W, 32, width of cycle_count

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; priority over every other input
- cmd_valid  in  1  command offered this cycle
- cmd_code  in  2  00 NOP, 01 RUN, 10 STEP, 11 HALT
- step_count  in  16  cycle count for STEP; sampled only on STEP transfer
- cmd_ready  out  1  controller accepts a command this cycle
- instruction_IF  in  32  word currently presented by the fetch block
- pipe_enable  out  1  1 = PC and all pipeline registers advance this cycle
- fetch_hold  out  1  1 = PC_write low and IF/ID loads a nop (pipeline still advances)
- state  out  3  000 IDLE, 001 RUN, 010 STEP, 011 DRAIN, 100 DONE
- busy  out  1  state is RUN, STEP or DRAIN
- done  out  1  state is DONE
- cycle_count  out  CNT_W  number of cycles with pipe_enable=1, saturating

## Operation
- Command transfer happens on a rising edge with cmd_valid & cmd_ready. cmd_ready = 1 in IDLE and RUN; 0 in STEP, DRAIN and DONE.
- IDLE: pipe_enable=0.
  - RUN goes to RUN.
  - STEP with step_count N>0 goes to STEP and loads remaining=N. STEP with N=0 is accepted with no effect.
  - HALT and NOP are accepted with no effect.
- RUN: pipe_enable=1.
  - HALT goes to IDLE; the pipeline is frozen with its contents intact and can be resumed.
  - RUN, STEP and NOP are accepted and ignored (step_count is not loaded).
- STEP: pipe_enable=1 and remaining decrements each cycle. The cycle with remaining==1 is the last enabled cycle; the next state is IDLE.
- Halt hit = (state RUN or STEP) & instruction_IF==HALT_WORD.
  - On a hit, fetch_hold=1 combinationally in that same cycle, so the halt word never enters IF/ID. pipe_enable stays 1 that cycle. Next state is DRAIN and the drain counter loads DRAIN_CYCLES.
  - A hit overrides a simultaneous HALT command (the command is accepted and discarded) and overrides a STEP remaining==1 exit (any remaining steps are discarded).
- DRAIN: pipe_enable=1 and fetch_hold=1. The drain counter decrements; after exactly DRAIN_CYCLES cycles the next state is DONE. Commands are not accepted.
- DONE: pipe_enable=0, fetch_hold=0, done=1. Only reset leaves DONE.
- fetch_hold is 0 whenever pipe_enable=0.
- cycle_count increments by 1 on each edge where pipe_enable was 1, and holds at 2^CNT_W−1.
- Reset, including mid-RUN, mid-STEP or mid-DRAIN: next state IDLE; remaining, drain counter and cycle_count clear. A command offered with reset high is dropped.

## Timing
- Reset values: state=IDLE, pipe_enable=0, fetch_hold=0, cmd_ready=1, busy=0, done=0, cycle_count=0.
- pipe_enable, busy, done and cmd_ready are decoded from the registered state only, so they have no combinational path from inputs.
- fetch_hold is the only output with a combinational input path (from instruction_IF).
- Command latency: a RUN or STEP transfer at edge k gives pipe_enable=1 from cycle k+1. A HALT transfer at edge k gives pipe_enable=0 from cycle k+1.
- STEP N yields exactly N consecutive enabled cycles.
- From a halt hit in cycle h: enabled cycles are h..h+DRAIN_CYCLES, done=1 from cycle h+DRAIN_CYCLES+1, and cycle_count grows by DRAIN_CYCLES+1 over that span.

## Test plan
- Reset then STEP N=3 -> pipe_enable high for exactly 3 cycles, state returns to 000, cycle_count=3, cmd_ready low during the step and high afterwards.
- RUN, 10 cycles, HALT, RUN again -> 10 enabled cycles, then pipe_enable=0 with the pipeline frozen, then enable resumes; cycle_count continues from 10 with no reset.
- RUN and present HALT_WORD at cycle h -> fetch_hold=1 in cycle h, DRAIN for cycles h+1..h+4, done=1 at h+5; RUN/STEP commands offered in DONE see cmd_ready=0.
- Halt word in the same cycle as a HALT command, and separately on the last STEP cycle (remaining==1) -> DRAIN entered in both cases; the HALT command and the remaining steps are discarded.
- Reset asserted mid-DRAIN with cmd_valid=1 and code RUN -> state=IDLE, cycle_count=0, all reset values hold, command dropped.
- CNT_W=4 build, RUN for 20 cycles -> cycle_count saturates at 15; STEP N=0 in IDLE -> no enable pulse, state stays IDLE.
